// File: rtl/cordic_arbiter.sv
// Round-robin arbiter that shares one CORDIC core between N_REQ requesters.
// States: IDLE arbitrate | ISSUE start pulse | RUN await done / watchdog | CAPTURE latch result.
module cordic_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [18*N_REQ-1:0]   req_x0,
  input  logic [18*N_REQ-1:0]   req_y0,
  input  logic [18*N_REQ-1:0]   req_z0,
  input  logic [N_REQ-1:0]      req_mode,
  input  logic [4*N_REQ-1:0]    req_niter,
  output logic [N_REQ-1:0]      ack,
  output logic                  core_start,
  output logic [17:0]           core_x0,
  output logic [17:0]           core_y0,
  output logic [17:0]           core_z0,
  output logic                  core_rot0_vec1,
  output logic [3:0]            core_n_iter,
  input  logic                  core_done,
  input  logic                  core_busy,
  input  logic [18:0]           core_xn,
  input  logic [18:0]           core_yn,
  input  logic [17:0]           core_zn,
  output logic                  res_valid,
  output logic [ID_W-1:0]       res_id,
  output logic [18:0]           res_xn,
  output logic [18:0]           res_yn,
  output logic [17:0]           res_zn,
  output logic                  err,
  output logic [ID_W-1:0]       err_id
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W:0]   N_W     = (ID_W + 1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  logic [1:0]      state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cur_id;
  logic [WD_W-1:0] wd;

  logic            found;
  logic [ID_W-1:0] winner;
  logic [ID_W:0]   idx_sum;
  logic [ID_W:0]   idx;
  logic            grant;
  logic [ID_W-1:0] next_ptr;

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    idx_sum = '0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_sum = {1'b0, ptr} + (ID_W + 1)'(i);
      idx     = (idx_sum >= N_W) ? (idx_sum - N_W) : idx_sum;
      if (!found && req[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  assign grant    = (state == S_IDLE) && found && !core_busy;
  assign next_ptr = (winner == LAST_ID) ? '0 : winner + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      ptr            <= '0;
      cur_id         <= '0;
      wd             <= '0;
      ack            <= '0;
      core_start     <= 1'b0;
      core_x0        <= '0;
      core_y0        <= '0;
      core_z0        <= '0;
      core_rot0_vec1 <= 1'b0;
      core_n_iter    <= '0;
      res_valid      <= 1'b0;
      res_id         <= '0;
      res_xn         <= '0;
      res_yn         <= '0;
      res_zn         <= '0;
      err            <= 1'b0;
      err_id         <= '0;
    end else begin
      ack        <= '0;
      core_start <= 1'b0;
      res_valid  <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            core_x0        <= req_x0[int'(winner)*18 +: 18];
            core_y0        <= req_y0[int'(winner)*18 +: 18];
            core_z0        <= req_z0[int'(winner)*18 +: 18];
            core_rot0_vec1 <= req_mode[winner];
            core_n_iter    <= req_niter[int'(winner)*4 +: 4];
            ack            <= N_REQ'(1) << winner;
            cur_id         <= winner;
            ptr            <= next_ptr;
            core_start     <= 1'b1;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd    <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          // Results settle one edge after done, so they are taken in CAPTURE.
          if (core_done) begin
            state <= S_CAPTURE;
          end else if (wd == WD_LAST) begin
            err    <= 1'b1;
            err_id <= cur_id;
            state  <= S_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_CAPTURE: begin
          res_xn    <= core_xn;
          res_yn    <= core_yn;
          res_zn    <= core_zn;
          res_id    <= cur_id;
          res_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: stand-in CORDIC core, event-schedule model and directed tests.
module tb_cordic_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0;
  logic [18*N-1:0] req_x0 = '0, req_y0 = '0, req_z0 = '0;
  logic [N-1:0]    req_mode = '0;
  logic [4*N-1:0]  req_niter = '0;
  logic [N-1:0]    ack;
  logic            core_start, core_rot0_vec1;
  logic [17:0]     core_x0, core_y0, core_z0;
  logic [3:0]      core_n_iter;
  logic            core_done, core_busy;
  logic [18:0]     core_xn, core_yn;
  logic [17:0]     core_zn;
  logic            res_valid, err;
  logic [IDW-1:0]  res_id, err_id;
  logic [18:0]     res_xn, res_yn;
  logic [17:0]     res_zn;
  logic            stall = 1'b0;

  cordic_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_x0(req_x0), .req_y0(req_y0), .req_z0(req_z0),
    .req_mode(req_mode), .req_niter(req_niter), .ack(ack), .core_start(core_start),
    .core_x0(core_x0), .core_y0(core_y0), .core_z0(core_z0), .core_rot0_vec1(core_rot0_vec1),
    .core_n_iter(core_n_iter), .core_done(core_done), .core_busy(core_busy),
    .core_xn(core_xn), .core_yn(core_yn), .core_zn(core_zn), .res_valid(res_valid),
    .res_id(res_id), .res_xn(res_xn), .res_yn(res_yn), .res_zn(res_zn), .err(err), .err_id(err_id));

  function automatic logic [18:0] fx(input logic [17:0] x, input logic [3:0] n);
    return {x[17], x} + 19'(n) + 19'd1;
  endfunction
  function automatic logic [18:0] fy(input logic [17:0] y, input logic [3:0] n);
    return {y[17], y} - 19'(n);
  endfunction
  function automatic logic [17:0] fz(input logic [17:0] z, input logic m, input logic [3:0] n);
    return z ^ {13'd0, m, n};
  endfunction

  // Stand-in core: n iterations after start, done pulse, results one edge after done.
  logic [4:0]  c_cnt;
  logic        c_stall, c_m;
  logic [17:0] c_x, c_y, c_z;
  logic [3:0]  c_n;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_busy <= 1'b0; core_done <= 1'b0; c_cnt <= '0; c_stall <= 1'b0;
      c_x <= '0; c_y <= '0; c_z <= '0; c_m <= 1'b0; c_n <= '0;
      core_xn <= '0; core_yn <= '0; core_zn <= '0;
    end else if (!core_busy) begin
      if (core_start) begin
        core_busy <= 1'b1;
        c_cnt     <= (core_n_iter == 4'd0) ? 5'd16 : {1'b0, core_n_iter};
        c_stall   <= stall;
        c_x <= core_x0; c_y <= core_y0; c_z <= core_z0; c_m <= core_rot0_vec1; c_n <= core_n_iter;
      end
    end else if (core_done) begin
      core_done <= 1'b0;
      core_busy <= 1'b0;
      core_xn   <= fx(c_x, c_n);
      core_yn   <= fy(c_y, c_n);
      core_zn   <= fz(c_z, c_m, c_n);
    end else if (c_stall) begin
      if (!stall) core_busy <= 1'b0;
    end else begin
      if (c_cnt == 5'd1) core_done <= 1'b1;
      c_cnt <= c_cnt - 5'd1;
    end
  end

  // Model: one job at a time, events scheduled relative to the grant edge.
  int e = 0, free_e = 0, mptr = 0, j_e0 = 0, j_n = 0, j_id = 0;
  bit job = 0, j_stall = 0, found_w;
  logic [17:0]    m_x = '0, m_y = '0, m_z = '0;
  logic           m_m = 1'b0;
  logic [3:0]     m_n = '0;
  logic [N-1:0]   x_ack = '0;
  bit             x_start = 0, x_rv = 0, x_err = 0;
  logic [IDW-1:0] x_rid = '0, x_eid = '0;
  logic [18:0]    x_xn = '0, x_yn = '0;
  logic [17:0]    x_zn = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      job = 0; free_e = 0; mptr = 0;
      m_x = '0; m_y = '0; m_z = '0; m_m = 1'b0; m_n = '0;
      x_ack = '0; x_start = 0; x_rv = 0; x_err = 0;
      x_rid = '0; x_eid = '0; x_xn = '0; x_yn = '0; x_zn = '0;
    end else begin
      e++;
      x_ack = '0; x_start = 0; x_rv = 0; x_err = 0;
      if (job) begin
        if (!j_stall && e == j_e0 + j_n + 3) begin
          x_rv = 1; x_rid = IDW'(j_id);
          x_xn = fx(m_x, m_n); x_yn = fy(m_y, m_n); x_zn = fz(m_z, m_m, m_n);
          job = 0; free_e = e + 1;
        end else if (j_stall && e == j_e0 + TO + 1) begin
          x_err = 1; x_eid = IDW'(j_id);
          job = 0; free_e = e + 1;
        end
      end else if (e >= free_e && req != '0 && !core_busy) begin
        found_w = 0;
        for (int k = 0; k < N; k++) begin
          if (!found_w && req[(mptr + k) % N]) begin
            found_w = 1;
            j_id = (mptr + k) % N;
          end
        end
        mptr = (j_id + 1) % N;
        x_ack = N'(1) << j_id; x_start = 1;
        m_x = req_x0[j_id*18 +: 18]; m_y = req_y0[j_id*18 +: 18]; m_z = req_z0[j_id*18 +: 18];
        m_m = req_mode[j_id]; m_n = req_niter[j_id*4 +: 4];
        j_n = (m_n == 4'd0) ? 16 : int'(m_n);
        j_e0 = e; j_stall = stall; job = 1;
      end
    end
  end

  int passed = 0, total = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, e);
  endtask
  task automatic timeout_fail(input string nm);
    total++;
    $display("FAIL %s: timed out, got no event want one (cycle %0d)", nm, e);
  endtask

  always @(negedge clk) begin
    chk("ack", 32'(ack), 32'(x_ack));
    chk("core_start", 32'(core_start), 32'(x_start));
    chk("res_valid", 32'(res_valid), 32'(x_rv));
    chk("err", 32'(err), 32'(x_err));
    chk("res_id", 32'(res_id), 32'(x_rid));
    chk("err_id", 32'(err_id), 32'(x_eid));
    chk("res_xn", 32'(res_xn), 32'(x_xn));
    chk("res_yn", 32'(res_yn), 32'(x_yn));
    chk("res_zn", 32'(res_zn), 32'(x_zn));
    chk("core_x0", 32'(core_x0), 32'(m_x));
    chk("core_y0", 32'(core_y0), 32'(m_y));
    chk("core_z0", 32'(core_z0), 32'(m_z));
    chk("core_mode", 32'(core_rot0_vec1), 32'(m_m));
    chk("core_n_iter", 32'(core_n_iter), 32'(m_n));
    chk("start_while_busy", 32'(core_start & core_busy), 32'd0);
  end

  task automatic set_op(input int k, input logic [17:0] x, input logic [17:0] y,
                        input logic [17:0] z, input logic m, input logic [3:0] n);
    req_x0[k*18 +: 18] = x; req_y0[k*18 +: 18] = y; req_z0[k*18 +: 18] = z;
    req_mode[k] = m; req_niter[k*4 +: 4] = n;
  endtask

  // kind 0: ack, 1: res_valid, 2: err. Returns the cycle index and the acked id.
  task automatic wait_for(input int kind, input int maxc, input string nm,
                          output int at, output int id);
    bit got = 0;
    at = -1; id = -1;
    for (int c = 0; c < maxc && !got; c++) begin
      @(negedge clk); #1;
      if ((kind == 0 && ack != '0) || (kind == 1 && res_valid) || (kind == 2 && err)) begin
        got = 1; at = e;
        for (int b = 0; b < N; b++) if (ack[b]) id = b;
      end
    end
    if (!got) timeout_fail(nm);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1; rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  int a_e, r_e, id, dummy, nack;
  int exp_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    idle(2);
    rst = 1'b0;
    chk("reset_ack", 32'(ack), 32'd0);

    // Single job, niter=12.
    set_op(0, 18'h04000, 18'h0, 18'h08000, 1'b0, 4'd12);
    req = 4'b0001;
    wait_for(0, 10, "t1_ack", a_e, id);
    req = '0;
    chk("t1_ack_id", 32'(id), 32'd0);
    chk("t1_start", 32'(core_start), 32'd1);
    wait_for(1, 40, "t1_res", r_e, dummy);
    chk("t1_latency", 32'(r_e - a_e), 32'd15);
    chk("t1_res_id", 32'(res_id), 32'd0);
    chk("t1_res_xn", 32'(res_xn), 32'h0400D);
    chk("t1_res_yn", 32'(res_yn), 32'h7FFF4);
    chk("t1_res_zn", 32'(res_zn), 32'h0800C);
    idle(2);

    // All four requesting, niter=4.
    do_reset();
    for (int k = 0; k < N; k++) set_op(k, 18'(k * 18'h111 + 18'h20), 18'(k * 18'h0F0), 18'(18'h3F000 - k), k[0], 4'd4);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_for(0, 20, "t2_ack", a_e, id);
      chk("t2_order", 32'(id), 32'(exp_seq[j]));
    end
    req = '0;
    idle(12);

    // Wrap from ptr=3: grant 2, then 0101 gives 0 then 2.
    set_op(2, 18'h00123, 18'h00456, 18'h00789, 1'b0, 4'd2);
    req = 4'b0100;
    wait_for(0, 20, "t3_ack_a", a_e, id);
    chk("t3_first", 32'(id), 32'd2);
    req = 4'b0101;
    wait_for(0, 20, "t3_ack_b", a_e, id);
    chk("t3_wrap", 32'(id), 32'd0);
    req = 4'b0100;
    wait_for(0, 20, "t3_ack_c", a_e, id);
    chk("t3_then", 32'(id), 32'd2);
    req = '0;
    idle(10);

    // Stalled core: watchdog error, no grant while busy.
    stall = 1'b1;
    set_op(3, 18'h01111, 18'h02222, 18'h03333, 1'b1, 4'd5);
    req = 4'b1000;
    wait_for(0, 10, "t4_ack", a_e, id);
    req = 4'b0010;
    wait_for(2, 40, "t4_err", r_e, dummy);
    chk("t4_err_time", 32'(r_e - a_e), 32'(TO + 1));
    chk("t4_err_id", 32'(err_id), 32'd3);
    nack = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (ack != '0) nack++;
    end
    chk("t4_no_grant_busy", 32'(nack), 32'd0);
    stall = 1'b0;
    wait_for(0, 10, "t4_ack_after", a_e, id);
    chk("t4_after_id", 32'(id), 32'd1);
    req = '0;
    wait_for(1, 30, "t4_res", r_e, dummy);
    idle(2);

    // Reset in RUN, then ptr restarts at 0.
    req = 4'b0010;
    wait_for(0, 10, "t5_ack", a_e, id);
    req = '0;
    idle(4);
    rst = 1'b1; #1;
    chk("t5_rst_core_x0", 32'(core_x0), 32'd0);
    chk("t5_rst_res_xn", 32'(res_xn), 32'd0);
    chk("t5_rst_n_iter", 32'(core_n_iter), 32'd0);
    idle(2);
    rst = 1'b0;
    req = 4'b1010;
    wait_for(0, 10, "t5_ack2", a_e, id);
    chk("t5_ptr0", 32'(id), 32'd1);
    req = '0;
    wait_for(1, 30, "t5_res", r_e, dummy);
    idle(2);

    // niter=0 (16 iterations), vectoring, negative x0.
    set_op(2, 18'h30000, 18'h01000, 18'h0, 1'b1, 4'd0);
    req = 4'b0100;
    wait_for(0, 10, "t6_ack", a_e, id);
    req = '0;
    chk("t6_id", 32'(id), 32'd2);
    wait_for(1, 40, "t6_res", r_e, dummy);
    chk("t6_latency", 32'(r_e - a_e), 32'd19);
    chk("t6_res_xn", 32'(res_xn), 32'h70001);
    chk("t6_res_yn", 32'(res_yn), 32'h01000);
    chk("t6_res_zn", 32'(res_zn), 32'h00010);
    idle(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, want finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
Round-robin arbiter and sequencer that shares one cordic_top core between N_REQ requesters. It accepts a request and latches that requester's operands, mode and iteration count. It then issues a one-cycle start to the core, holds the mode and n_iter config stable for the whole run, captures the core result and returns it tagged with the requester ID. A watchdog flags a core that never signals done.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width, equal to clog2(N_REQ)
TIMEOUT_CYC, 24, maximum cycles in RUN waiting for core_done before error (must exceed 17)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
req  in  N_REQ  level request per requester; held until its ack
req_x0  in  18*N_REQ  packed x0 per requester, slice k = [18k+17:18k]
req_y0  in  18*N_REQ  packed y0
req_z0  in  18*N_REQ  packed z0
req_mode  in  N_REQ  rot0_vec1 per requester
req_niter  in  4*N_REQ  n_iter per requester
ack  out  N_REQ  one-hot, one-cycle pulse: request accepted, operands latched
core_start  out  1  start to core
core_x0/core_y0/core_z0  out  18 each  latched operands
core_rot0_vec1  out  1  latched mode
core_n_iter  out  4  latched iteration count
core_done  in  1  core done pulse
core_busy  in  1  core busy
core_xn/core_yn  in  19 each  core results
core_zn  in  18  core result
res_valid  out  1  one-cycle pulse: res_* valid
res_id  out  ID_W  requester owning the result
res_xn/res_yn  out  19 each  captured result
res_zn  out  18  captured result
err  out  1  one-cycle pulse on watchdog timeout
err_id  out  ID_W  requester whose job timed out

Behaviour:
- Reset (async, rst=1): state IDLE, rr pointer 0, watchdog 0. All outputs 0: ack, core_*, res_*, err, err_id. Reset mid-job aborts the job silently. The core shares rst, so both return to idle.
- States: IDLE, ISSUE, RUN, CAPTURE.
- IDLE: if req!=0 and core_busy==0, pick the winner by round robin.
  - Search order is ptr, ptr+1, …, wrapping modulo N_REQ. ptr becomes winner+1 (mod N_REQ).
  - At that edge: latch the winner's x0/y0/z0/mode/niter into the core_* registers, pulse ack[winner], store the ID, go to ISSUE.
  - If core_busy==1 (e.g. after a timeout), stay in IDLE and grant nothing.
- ISSUE: core_start=1 for exactly this cycle. Then go to RUN and clear the watchdog.
- RUN: core_start=0. core_x0/y0/z0/rot0_vec1/n_iter stay constant, because the core uses mode and n_iter every iteration.
  - When core_done==1, go to CAPTURE. core_xn/yn/zn update on the edge after done, so they are not sampled in this cycle.
  - Otherwise increment the watchdog. On reaching TIMEOUT_CYC: pulse err, set err_id=ID, go to IDLE, no res_valid.
- CAPTURE: at the edge, res_xn/yn/zn <= core_xn/yn/zn, res_id <= ID, res_valid <= 1 for one cycle, go to IDLE.
- res_* hold their value until the next capture. Only res_valid and err are pulses.
- Latency: acceptance edge E0. core_start is sampled at E0+1. res_valid is high in the cycle after edge E0+n+3, where n = n_iter, and n_iter=0 counts as 16 (core behaviour). Back-to-back jobs: the next grant can occur in the cycle after CAPTURE.
- n_iter is passed through unmodified. Operand widths are passed through; there is no arithmetic in the arbiter.
- Requirements on requesters:
  - A requester that keeps req high after its ack is re-arbitrated as a new job.
  - Operands need only be valid in the cycle req is high before ack.
  - Changes to req while RUN is active have no effect on the active job.
- Simultaneous requests: exactly one ack per grant. The others wait, with no starvation; a waiting requester is granted within N_REQ-1 jobs.

Test Plan:
- Reset then single req[0]: x0=0x04000, y0=0, z0=0x08000, mode=0, niter=12 -> ack[0] one cycle. core_start exactly 1 cycle, core_n_iter=12 held through RUN. res_valid 15 cycles after the acceptance edge, res_id=0, res_* equal to core outputs.
- req=4'b1111 held, each niter=4 -> acks in order 0,1,2,3,0 with one ack per job. res_id sequence matches. No overlap of core_start with core_busy.
- After a grant to 2, req=4'b0101 -> next grant to 0 (wrap from ptr=3), then 2.
- Force core_done stuck low (core model stalled) -> err pulse TIMEOUT_CYC cycles into RUN, err_id correct, no res_valid. No new grant while core_busy=1.
- Assert rst during RUN -> all outputs 0 immediately, state IDLE. After release, new req is served normally with ptr=0.
- niter=0 with mode=1, x0 negative -> core_n_iter=0 and core_rot0_vec1=1 stable for 16 iterations. res_valid 19 cycles after acceptance.
